program_loader: RTL and testbench

// - Upstream of inst_fetch. Turns the raw UART RX byte stream into inst_fetch's program-loader strobes:

---
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader.sv | 169 ++++++++++++++++
 tb/tb_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream interface between the UART RX side, the program loader and
// inst_fetch.
//   rx_data/rx_valid/load_req       : producer -> loader
//   input_data/valid/start/end      : loader -> inst_fetch strobes
//   busy/done/error                 : loader status levels
// modport slave is the loader's view; modport master is the view of whoever
// drives the received bytes and consumes the loader outputs.
interface program_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       load_req;
   logic [7:0] input_data;
   logic       input_valid;
   logic       input_start;
   logic       input_end;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output rx_data, rx_valid, load_req,
      input  input_data, input_valid, input_start, input_end, busy, done, error
   );

   modport slave (
      input  rx_data, rx_valid, load_req,
      output input_data, input_valid, input_start, input_end, busy, done, error
   );
endinterface

// File: rtl/program_loader.sv
// Program loader: turns the UART RX byte stream into inst_fetch's loader
// strobes. A 4-byte big-endian word-count header is parsed first. Then
// 4*N payload bytes are forwarded, one per strobe, bracketed by
// input_start/input_end pulses. Bad headers and stalled transfers set error.
// Ports:
//   CLK    : clock
//   reset  : asynchronous, active-low reset
//   pl     : program_loader_if.slave (rx byte input, load_req, loader strobes, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LEN   | armed, collecting the 4 header bytes MSB first
// S_START | input_start pulse on the outputs; a byte here is still accepted
// S_DATA  | forwarding payload bytes, idle timer running
// S_END   | last payload byte is on the outputs; schedule input_end + done
// S_DONE  | load finished normally; wait for load_req
// S_ERROR | header rejected or payload timed out; wait for load_req
module program_loader #(
   parameter int unsigned INST_MEM_WIDTH = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic            CLK,
   input  logic            reset,
   program_loader_if.slave pl
);
   localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
   localparam logic [31:0]   MAX_WORDS  = 32'd1 << INST_MEM_WIDTH;

   typedef enum logic [2:0] {
      S_LEN, S_START, S_DATA, S_END, S_DONE, S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   len_q, len_d;
   logic [31:0]   remaining_q, remaining_d;
   logic [1:0]    hdr_cnt_q, hdr_cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    input_data_q, input_data_d;
   logic          input_valid_q, input_valid_d;
   logic          input_start_q, input_start_d;
   logic          input_end_q, input_end_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [31:0]   len_next;

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      remaining_d   = remaining_q;
      hdr_cnt_d     = hdr_cnt_q;
      timer_d       = timer_q;
      input_data_d  = input_data_q;
      input_valid_d = 1'b0;
      input_start_d = 1'b0;
      input_end_d   = 1'b0;
      done_d        = done_q;
      error_d       = error_q;
      len_next      = {len_q[23:0], pl.rx_data};

      case (state_q)
         S_LEN: begin
            if (pl.rx_valid) begin
               len_d     = len_next;
               hdr_cnt_d = hdr_cnt_q + 2'd1;
               if (hdr_cnt_q == 2'd3) begin
                  if ((len_next == 32'd0) || (len_next > MAX_WORDS)) begin
                     error_d = 1'b1;
                     state_d = S_ERROR;
                  end else begin
                     remaining_d   = {len_next[29:0], 2'b00};
                     input_start_d = 1'b1;
                     state_d       = S_START;
                  end
               end
            end
         end
         S_START: begin
            // A byte arriving while input_start is out is captured straight
            // into the output register, so it shows up in DATA's first cycle.
            // remaining is at least 4 here, so it cannot finish the load.
            timer_d = TIMER_LOAD;
            state_d = S_DATA;
            if (pl.rx_valid) begin
               input_data_d  = pl.rx_data;
               input_valid_d = 1'b1;
               remaining_d   = remaining_q - 32'd1;
            end
         end
         S_DATA: begin
            if (pl.rx_valid) begin
               input_data_d  = pl.rx_data;
               input_valid_d = 1'b1;
               remaining_d   = remaining_q - 32'd1;
               timer_d       = TIMER_LOAD;
               if (remaining_q == 32'd1) begin
                  state_d = S_END;
               end
            end else if (timer_q == TW'(1)) begin
               // This is the TIMEOUT_CYCLES-th consecutive idle cycle.
               input_end_d = 1'b1;
               error_d     = 1'b1;
               state_d     = S_ERROR;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_END: begin
            input_end_d = 1'b1;
            done_d      = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE, S_ERROR: begin
            if (pl.load_req) begin
               state_d     = S_LEN;
               done_d      = 1'b0;
               error_d     = 1'b0;
               len_d       = 32'd0;
               hdr_cnt_d   = 2'd0;
               remaining_d = 32'd0;
               timer_d     = '0;
            end
         end
         default: state_d = S_LEN;
      endcase

      busy_d = (state_d == S_LEN) || (state_d == S_START) ||
               (state_d == S_DATA) || (state_d == S_END);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q       <= S_LEN;
         len_q         <= 32'd0;
         remaining_q   <= 32'd0;
         hdr_cnt_q     <= 2'd0;
         timer_q       <= '0;
         input_data_q  <= 8'd0;
         input_valid_q <= 1'b0;
         input_start_q <= 1'b0;
         input_end_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         remaining_q   <= remaining_d;
         hdr_cnt_q     <= hdr_cnt_d;
         timer_q       <= timer_d;
         input_data_q  <= input_data_d;
         input_valid_q <= input_valid_d;
         input_start_q <= input_start_d;
         input_end_q   <= input_end_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   assign pl.input_data  = input_data_q;
   assign pl.input_valid = input_valid_q;
   assign pl.input_start = input_start_q;
   assign pl.input_end   = input_end_q;
   assign pl.busy        = busy_q;
   assign pl.done        = done_q;
   assign pl.error       = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. Input and output events are logged with a
// cycle stamp. A transaction-level model then derives the expected
// start/valid/end events and final status from the logged input events.
module tb_program_loader;
   localparam int TMO       = 50;
   localparam int MAX_WORDS = 4;

   logic CLK   = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   program_loader_if pl ();

   program_loader #(.INST_MEM_WIDTH(2), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK  (CLK),
      .reset(reset),
      .pl   (pl)
   );

   typedef struct {
      int         cyc;
      bit         is_byte;
      bit         is_load;
      logic [7:0] d;
   } in_ev_t;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } out_ev_t;

   in_ev_t  in_log[$];
   out_ev_t act_v[$];
   out_ev_t exp_v[$];
   int      act_s[$], act_e[$], exp_s[$], exp_e[$];
   int      cyc = 0;
   bit      overlap_seen = 1'b0;
   int      tests = 0;
   int      fails = 0;

   always @(negedge CLK) begin
      cyc++;
      if (reset) begin
         if (pl.rx_valid || pl.load_req)
            in_log.push_back('{cyc, pl.rx_valid, pl.load_req, pl.rx_data});
         if (pl.input_valid) act_v.push_back('{cyc, pl.input_data});
         if (pl.input_start) act_s.push_back(cyc);
         if (pl.input_end)   act_e.push_back(cyc);
         if (pl.input_start && pl.input_end) overlap_seen = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] b);
      pl.rx_data  = b;
      pl.rx_valid = 1'b1;
      step();
      pl.rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] n);
      for (int i = 3; i >= 0; i--) send(n[8*i +: 8]);
   endtask

   task automatic pulse_load();
      pl.load_req = 1'b1;
      step();
      pl.load_req = 1'b0;
   endtask

   task automatic clear_logs();
      in_log.delete();
      act_v.delete();
      act_s.delete();
      act_e.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " input_valid"}, 64'(pl.input_valid), 64'd0);
      chk({tag, " input_start"}, 64'(pl.input_start), 64'd0);
      chk({tag, " input_end"},   64'(pl.input_end),   64'd0);
      chk({tag, " input_data"},  64'(pl.input_data),  64'd0);
      chk({tag, " busy"},        64'(pl.busy),        64'd0);
      chk({tag, " done"},        64'(pl.done),        64'd0);
      chk({tag, " error"},       64'(pl.error),       64'd0);
   endtask

   // Phases: 0 = collecting header, 1 = payload, 2 = done, 3 = error.
   // A byte at cycle c is echoed at c+1; the end pulse follows the last echo
   // by one cycle; a payload stall of TMO idle cycles ends with an end pulse
   // and error. load_req is honoured only once the load is really finished.
   task automatic run_model(input bit armed, output int ph);
      int          nh;
      logic [31:0] len;
      int          rem;
      int          last_ref;
      int          ready_cyc;
      exp_v.delete();
      exp_s.delete();
      exp_e.delete();
      ph        = armed ? 0 : 3;
      nh        = 0;
      len       = 32'd0;
      rem       = 0;
      last_ref  = 0;
      ready_cyc = 0;
      foreach (in_log[i]) begin
         if (ph == 1 && in_log[i].cyc > last_ref + TMO) begin
            exp_e.push_back(last_ref + TMO + 1);
            ph        = 3;
            ready_cyc = last_ref + TMO + 1;
         end
         if (in_log[i].is_byte) begin
            if (ph == 0) begin
               len = {len[23:0], in_log[i].d};
               nh++;
               if (nh == 4) begin
                  if (len == 0 || len > MAX_WORDS) begin
                     ph        = 3;
                     ready_cyc = in_log[i].cyc + 1;
                  end else begin
                     ph       = 1;
                     rem      = int'(len) * 4;
                     exp_s.push_back(in_log[i].cyc + 1);
                     last_ref = in_log[i].cyc + 1;
                  end
               end
            end else if (ph == 1) begin
               exp_v.push_back('{in_log[i].cyc + 1, in_log[i].d});
               last_ref = in_log[i].cyc;
               rem--;
               if (rem == 0) begin
                  exp_e.push_back(in_log[i].cyc + 2);
                  ph        = 2;
                  ready_cyc = in_log[i].cyc + 2;
               end
            end
         end
         if (in_log[i].is_load && ph >= 2 && in_log[i].cyc >= ready_cyc) begin
            ph  = 0;
            nh  = 0;
            len = 32'd0;
         end
      end
      if (ph == 1 && cyc >= last_ref + TMO + 1) begin
         exp_e.push_back(last_ref + TMO + 1);
         ph = 3;
      end
   endtask

   task automatic compare(input string tag, input bit armed);
      int ph;
      int n;
      run_model(armed, ph);
      chk({tag, " start count"}, 64'(act_s.size()), 64'(exp_s.size()));
      n = (act_s.size() < exp_s.size()) ? act_s.size() : exp_s.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s start cyc[%0d]", tag, i), 64'(act_s[i]), 64'(exp_s[i]));
      chk({tag, " end count"}, 64'(act_e.size()), 64'(exp_e.size()));
      n = (act_e.size() < exp_e.size()) ? act_e.size() : exp_e.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s end cyc[%0d]", tag, i), 64'(act_e[i]), 64'(exp_e[i]));
      chk({tag, " valid count"}, 64'(act_v.size()), 64'(exp_v.size()));
      n = (act_v.size() < exp_v.size()) ? act_v.size() : exp_v.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s valid cyc[%0d]", tag, i), 64'(act_v[i].cyc), 64'(exp_v[i].cyc));
         chk($sformatf("%s valid data[%0d]", tag, i), 64'(act_v[i].d), 64'(exp_v[i].d));
      end
      chk({tag, " done"},  64'(pl.done),  64'(ph == 2));
      chk({tag, " error"}, 64'(pl.error), 64'(ph == 3));
      chk({tag, " busy"},  64'(pl.busy),  64'(ph < 2));
   endtask

   initial begin
      int          nb;
      int          gap;
      int unsigned hdr;
      pl.rx_data  = 8'd0;
      pl.rx_valid = 1'b0;
      pl.load_req = 1'b0;

      #2 reset = 1'b0;
      #1 chk_zero("reset");
      repeat (3) @(posedge CLK);
      #1 reset = 1'b1;
      step();

      // One word, a byte every 4 cycles, with an ignored load_req mid-payload.
      clear_logs();
      send_hdr(32'd1);
      send(8'h11); idle(3);
      send(8'h22); pulse_load(); idle(2);
      send(8'h33); idle(3);
      send(8'h44); idle(3);
      idle(5);
      compare("one_word", 1'b1);
      chk("one_word data0", 64'(act_v.size() > 0 ? act_v[0].d : 8'hxx), 64'h11);
      chk("one_word data3", 64'(act_v.size() > 3 ? act_v[3].d : 8'hxx), 64'h44);

      // Full memory, back-to-back bytes (first one lands in the START cycle).
      clear_logs();
      pulse_load();
      send_hdr(32'd4);
      for (int i = 0; i < 16; i++) send(8'($urandom()));
      idle(5);
      compare("b2b16", 1'b0);

      // Oversized header, then a good load after re-arming.
      clear_logs();
      pulse_load();
      send_hdr(32'd5);
      send(8'hAA);
      idle(3);
      compare("len5", 1'b0);
      clear_logs();
      pulse_load();
      send_hdr(32'd1);
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 5));
         send(8'($urandom()));
      end
      idle(5);
      compare("after_len5", 1'b0);

      // Zero-length header.
      clear_logs();
      pulse_load();
      send_hdr(32'd0);
      idle(3);
      compare("len0", 1'b0);

      // Stall after two payload bytes.
      clear_logs();
      pulse_load();
      send_hdr(32'd1);
      send(8'h5A);
      send(8'hA5);
      idle(TMO + 10);
      compare("timeout", 1'b0);
      chk("timeout end-after-last-valid",
          64'((act_e.size() > 0 && act_v.size() > 1) ? act_e[0] - act_v[1].cyc : -1),
          64'(TMO));

      // Reset in the middle of a payload.
      clear_logs();
      pulse_load();
      send_hdr(32'd1);
      send(8'h01);
      send(8'h02);
      idle(1);
      #2 reset = 1'b0;
      #1 chk_zero("midreset");
      chk("midreset no end", 64'(act_e.size()), 64'd0);
      @(posedge CLK);
      #1 reset = 1'b1;
      step();
      clear_logs();
      send_hdr(32'd1);
      for (int i = 0; i < 4; i++) send(8'($urandom()));
      idle(5);
      compare("post_reset", 1'b1);

      // Randomized loads: random length (including bad ones), random gaps,
      // occasional long stalls and short payloads, stray bytes afterwards.
      for (int r = 0; r < 8; r++) begin
         clear_logs();
         pulse_load();
         hdr = $urandom_range(0, 5);
         send_hdr(hdr);
         nb = (hdr == 0 || hdr > MAX_WORDS) ? 2 : int'(hdr) * 4;
         if (nb > 2 && $urandom_range(0, 3) == 0) nb = nb - int'($urandom_range(1, 2));
         for (int i = 0; i < nb; i++) begin
            gap = ($urandom_range(0, 19) == 0) ? TMO + 2 : int'($urandom_range(0, 3));
            idle(gap);
            send(8'($urandom()));
         end
         idle(TMO + 10);
         send(8'($urandom()));
         idle(2);
         compare($sformatf("rand%0d", r), 1'b0);
      end

      chk("start/end overlap", 64'(overlap_seen), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
